// File: rtl/dsp_pkg.sv
// Shared types and helpers for the sample-rate stages of the DSP chain.
package dsp_pkg;

    typedef enum logic {
        DECIM_DROP,
        DECIM_AVG
    } decim_mode_t;

    // Extra accumulator bits needed to sum DECIM samples without overflow.
    function automatic int ACC_EXT(input int decim);
        return $clog2(decim);
    endfunction

    // Half an LSB after a right shift by k, used for round-half-up.
    function automatic int ROUND_HALF(input int k);
        return 1 << (k - 1);
    endfunction

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle: data, valid, ready.
interface axis_if #(
    parameter int DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_fifo2.sv
// Two-entry AXI-Stream output buffer; slot 0 is always the head.
module axis_fifo2 #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    axis_if.master                m_axis
);

    logic [1:0]            fill_reg;
    logic [1:0]            fill_next;
    logic [DATA_WIDTH-1:0] slot_reg  [2];
    logic [DATA_WIDTH-1:0] slot_next [2];
    logic                  pop;

    assign pop = m_axis.tvalid & m_axis.tready;

    always_comb begin
        fill_next    = fill_reg;
        slot_next[0] = slot_reg[0];
        slot_next[1] = slot_reg[1];
        case ({push, pop})
            2'b10: begin
                fill_next = fill_reg + 2'd1;
                if (fill_reg == 2'd0) begin
                    slot_next[0] = push_data;
                end else begin
                    slot_next[1] = push_data;
                end
            end
            2'b01: begin
                fill_next    = fill_reg - 2'd1;
                slot_next[0] = slot_reg[1];
            end
            2'b11: begin
                // Head leaves while the new word enters behind whatever remains.
                if (fill_reg == 2'd1) begin
                    slot_next[0] = push_data;
                end else begin
                    slot_next[0] = slot_reg[1];
                    slot_next[1] = push_data;
                end
            end
            default: begin
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    slot_reg[gi] <= '0;
                end else begin
                    slot_reg[gi] <= slot_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fill_reg <= 2'd0;
        end else begin
            fill_reg <= fill_next;
        end
    end

    // Reports the fill after the current edge so the upstream ready can be registered.
    assign full          = (fill_next == 2'd2);
    assign m_axis.tvalid = (fill_reg != 2'd0);
    assign m_axis.tdata  = slot_reg[0];

endmodule

// File: rtl/axis_fir_decimator.sv
// Decimates the FIR output stream by DECIM, either keeping one phase or averaging each group.
module axis_fir_decimator
    import dsp_pkg::*;
#(
    parameter int          DATA_WIDTH = 16,
    parameter int          DECIM      = 4,
    parameter int          PHASE      = 0,
    parameter decim_mode_t MODE       = DECIM_DROP
) (
    input  logic   clk_i,
    input  logic   rst_i,
    axis_if.slave  s_axis,
    axis_if.master m_axis
);

    localparam int K     = ACC_EXT(DECIM);
    localparam int PH_W  = (K < 1) ? 1 : K;
    localparam int ACC_W = DATA_WIDTH + K;

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
    localparam logic [PH_W-1:0] PH_KEEP = PH_W'(PHASE);

    generate
        if (DECIM < 2) begin : g_chk_decim
            $error("axis_fir_decimator: DECIM must be at least 2");
        end
        if (PHASE < 0 || PHASE >= DECIM) begin : g_chk_phase
            $error("axis_fir_decimator: PHASE must lie in 0..DECIM-1");
        end
        if (MODE == DECIM_AVG && (DECIM & (DECIM - 1)) != 0) begin : g_chk_pow2
            $error("axis_fir_decimator: AVG mode needs a power-of-two DECIM");
        end
    endgenerate

    logic                  ready_reg;
    logic [PH_W-1:0]       phase_reg;
    logic [PH_W-1:0]       phase_next;
    logic                  accept;
    logic                  last;
    logic                  push;
    logic [DATA_WIDTH-1:0] push_data;
    logic                  buf_full;

    assign accept = s_axis.tvalid & ready_reg;
    assign last   = (phase_reg == PH_LAST);

    always_comb begin
        phase_next = phase_reg;
        if (accept) begin
            phase_next = last ? '0 : phase_reg + PH_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_reg <= '0;
            ready_reg <= 1'b0;
        end else begin
            phase_reg <= phase_next;
            ready_reg <= ~buf_full;
        end
    end

    assign s_axis.tready = ready_reg;

    generate
        if (MODE == DECIM_AVG) begin : g_avg
            logic signed [ACC_W-1:0] acc_reg;
            logic signed [ACC_W-1:0] sum;
            logic        [ACC_W-1:0] rnd;
            logic                    unused_round;

            assign sum = acc_reg + {{K{s_axis.tdata[DATA_WIDTH-1]}}, s_axis.tdata};
            assign rnd = sum + ACC_W'(ROUND_HALF(K));
            // Taking the top DATA_WIDTH bits is the arithmetic shift plus truncation.
            assign push_data    = rnd[ACC_W-1:K];
            assign unused_round = ^rnd[K-1:0];
            assign push         = accept & last;

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    acc_reg <= '0;
                end else if (accept) begin
                    acc_reg <= last ? '0 : sum;
                end
            end
        end else begin : g_drop
            assign push      = accept & (phase_reg == PH_KEEP);
            assign push_data = s_axis.tdata;
        end
    endgenerate

    axis_fifo2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .push      (push),
        .push_data (push_data),
        .full      (buf_full),
        .m_axis    (m_axis)
    );

endmodule

// File: tb/tb_axis_fir_decimator.sv
// Four decimator configurations driven side by side; a forked monitor checks outputs against a model queue.
module tb_axis_fir_decimator;
    import dsp_pkg::*;

    localparam int N = 4;
    localparam int W = 16;
    localparam int          DEC [N] = '{4, 4, 4, 2};
    localparam int          PH  [N] = '{0, 3, 0, 0};
    localparam decim_mode_t MD  [N] = '{DECIM_DROP, DECIM_DROP, DECIM_AVG, DECIM_DROP};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] s_tdata  [N];
    logic         s_tvalid [N];
    logic         s_tready [N];
    logic [W-1:0] m_tdata  [N];
    logic         m_tvalid [N];
    logic         m_tready [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_dut
            axis_if #(.DATA_WIDTH(W)) s_if ();
            axis_if #(.DATA_WIDTH(W)) m_if ();
            assign s_if.tdata    = s_tdata[gi];
            assign s_if.tvalid   = s_tvalid[gi];
            assign s_tready[gi]  = s_if.tready;
            assign m_tdata[gi]   = m_if.tdata;
            assign m_tvalid[gi]  = m_if.tvalid;
            assign m_if.tready   = m_tready[gi];

            axis_fir_decimator #(
                .DATA_WIDTH (W),
                .DECIM      (DEC[gi]),
                .PHASE      (PH[gi]),
                .MODE       (MD[gi])
            ) dut (
                .clk_i  (clk),
                .rst_i  (rst),
                .s_axis (s_if),
                .m_axis (m_if)
            );
        end
    endgenerate

    int tests = 0;
    int fails = 0;
    int out_cnt [N];
    int q0[$];
    int q1[$];
    int q2[$];
    int q3[$];
    int     grp_cnt [N];
    longint grp_sum [N];
    bit     rnd_on;

    function automatic void exp_push(input int idx, input int v);
        case (idx)
            0: q0.push_back(v);
            1: q1.push_back(v);
            2: q2.push_back(v);
            default: q3.push_back(v);
        endcase
    endfunction

    function automatic int exp_size(input int idx);
        case (idx)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic int exp_pop(input int idx);
        case (idx)
            0: return q0.pop_front();
            1: return q1.pop_front();
            2: return q2.pop_front();
            default: return q3.pop_front();
        endcase
    endfunction

    function automatic longint floor_div(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b) != 0 && a < 0) q = q - 1;
        return q;
    endfunction

    function automatic void model_reset();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        for (int i = 0; i < N; i++) begin
            grp_cnt[i] = 0;
            grp_sum[i] = 0;
        end
    endfunction

    // Group-level model: pick a phase, or average the group with round-half-up.
    function automatic void model_accept(input int idx, input logic [W-1:0] d);
        int x;
        x = int'($signed(d));
        if (MD[idx] == DECIM_DROP) begin
            if (grp_cnt[idx] == PH[idx]) exp_push(idx, x);
        end else begin
            grp_sum[idx] = grp_sum[idx] + x;
            if (grp_cnt[idx] == DEC[idx] - 1) begin
                exp_push(idx, int'(floor_div(grp_sum[idx] + DEC[idx] / 2, DEC[idx])));
                grp_sum[idx] = 0;
            end
        end
        grp_cnt[idx] = (grp_cnt[idx] + 1) % DEC[idx];
    endfunction

    function automatic void check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("[TB] FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endfunction

    task automatic monitor();
        int e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int i = 0; i < N; i++) begin
                    if (m_tvalid[i] && m_tready[i]) begin
                        out_cnt[i]++;
                        if (exp_size(i) == 0) begin
                            tests++;
                            fails++;
                            $display("[TB] FAIL unexpected_out inst=%0d got=%0d expected=none", i, $signed(m_tdata[i]));
                        end else begin
                            e = exp_pop(i);
                            $display("[TB] inst=%0d out=%0d exp=%0d", i, $signed(m_tdata[i]), e);
                            check($sformatf("out_inst%0d", i), int'($signed(m_tdata[i])), e);
                        end
                    end
                end
            end
        end
    endtask

    // Entered and left at posedge+1; holds tvalid until the sample is taken.
    task automatic send(input int idx, input int v, output int stalls);
        bit done;
        done   = 0;
        stalls = 0;
        s_tdata[idx]  = W'(v);
        s_tvalid[idx] = 1'b1;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge clk);
            if (s_tready[idx]) begin
                model_accept(idx, s_tdata[idx]);
                done = 1;
            end else begin
                stalls++;
            end
            @(posedge clk);
            #1;
        end
        s_tvalid[idx] = 1'b0;
        if (!done) check($sformatf("send_timeout_inst%0d", idx), 0, 1);
    endtask

    task automatic wait_drain(input int idx);
        int c;
        c = 0;
        while (exp_size(idx) != 0 && c < 500) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
        check($sformatf("drain_inst%0d", idx), exp_size(idx), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input bit check_state);
        rst = 1'b1;
        for (int i = 0; i < N; i++) s_tvalid[i] = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        if (check_state) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("rst_tvalid%0d", i), int'(m_tvalid[i]), 0);
                check($sformatf("rst_tdata%0d", i), int'(m_tdata[i]), 0);
                check($sformatf("rst_tready%0d", i), int'(s_tready[i]), 0);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int st;
        int tot;
        int base;
        bit prev_push;

        for (int i = 0; i < N; i++) begin
            s_tdata[i]  = '0;
            s_tvalid[i] = 1'b0;
            m_tready[i] = 1'b1;
            out_cnt[i]  = 0;
        end
        model_reset();
        fork
            monitor();
        join_none

        @(posedge clk);
        #1;
        do_reset(1'b1);

        // DROP PHASE=0: tvalid rises exactly one cycle after accepting 1, 5, 9.
        prev_push = 1'b0;
        for (int v = 1; v <= 12; v++) begin
            s_tdata[0]  = W'(v);
            s_tvalid[0] = 1'b1;
            @(negedge clk);
            check("latency_inst0", int'(m_tvalid[0]), int'(prev_push));
            check("ready_inst0", int'(s_tready[0]), 1);
            if (s_tready[0]) model_accept(0, s_tdata[0]);
            prev_push = s_tready[0] && (v % 4 == 1);
            @(posedge clk);
            #1;
        end
        s_tvalid[0] = 1'b0;
        wait_drain(0);
        check("count_inst0", out_cnt[0], 3);

        // DROP PHASE=3: 4,8,12; then a reset with 4 buffered must leave only 23.
        for (int v = 1; v <= 12; v++) send(1, v, st);
        wait_drain(1);
        check("count_inst1", out_cnt[1], 3);
        m_tready[1] = 1'b0;
        for (int v = 1; v <= 6; v++) send(1, v, st);
        @(negedge clk);
        check("held_valid_inst1", int'(m_tvalid[1]), 1);
        check("held_data_inst1", int'($signed(m_tdata[1])), 4);
        @(posedge clk);
        #1;
        do_reset(1'b0);
        m_tready[1] = 1'b1;
        base = out_cnt[1];
        for (int v = 20; v <= 23; v++) send(1, v, st);
        wait_drain(1);
        check("post_reset_count_inst1", out_cnt[1] - base, 1);

        // AVG DECIM=4 edge groups: 3, -2, 32767, -32768.
        for (int v = 1; v <= 4; v++) send(2, v, st);
        send(2, -1, st); send(2, -2, st); send(2, -2, st); send(2, -2, st);
        for (int i = 0; i < 4; i++) send(2, 32767, st);
        for (int i = 0; i < 4; i++) send(2, -32768, st);
        wait_drain(2);
        check("count_inst2", out_cnt[2], 4);

        // Backpressure on DECIM=2: two outputs buffered, input stalls, head held.
        m_tready[3] = 1'b0;
        base = out_cnt[3];
        for (int v = 10; v <= 12; v++) send(3, v, st);
        fork
            begin
                send(3, 13, st);
                send(3, 14, st);
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_ready_low", int'(s_tready[3]), 0);
                check("bp_valid", int'(m_tvalid[3]), 1);
                check("bp_head", int'($signed(m_tdata[3])), 10);
                @(posedge clk);
                #1;
                m_tready[3] = 1'b1;
            end
        join
        wait_drain(3);
        check("bp_count", out_cnt[3] - base, 3);

        // Continuous flow with an always-ready sink never stalls the input.
        tot = 0;
        for (int i = 0; i < 200; i++) begin
            send(3, int'($urandom_range(0, 65535)), st);
            tot += st;
        end
        check("no_stall_stream", tot, 0);
        wait_drain(3);

        // Random tvalid gaps and random sink backpressure on DROP and AVG.
        rnd_on = 1'b1;
        fork
            begin
                fork
                    for (int i = 0; i < 1000; i++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                        send(3, int'($urandom_range(0, 65535)), st);
                    end
                    for (int i = 0; i < 400; i++) begin
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                        send(2, int'($urandom_range(0, 65535)), st);
                    end
                join
                rnd_on = 1'b0;
            end
            begin
                while (rnd_on) begin
                    @(posedge clk);
                    #1;
                    m_tready[2] = ($urandom_range(0, 3) != 0);
                    m_tready[3] = ($urandom_range(0, 3) != 0);
                end
            end
        join
        m_tready[2] = 1'b1;
        m_tready[3] = 1'b1;
        wait_drain(2);
        wait_drain(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
